sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of switch inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz): consecutive stable cycles required; legal range >= 2.
REQ-003 SHALL have port CLK100MHZ  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SW  input  WIDTH  raw asynchronous board switches; SW[0]=a0, SW[1]=a1, SW[2]=b0, SW[3]=b1 of the 2-bit adder downstream.
REQ-006 SHALL have port SW_CLEAN  output  WIDTH  synchronized, debounced switch levels that feed the adder operands.
REQ-007 SHALL have port SW_CHANGED  output  1  one-cycle strobe on any SW_CLEAN update (see Configuration).

Function
REQ-008 SHALL pass each SW bit through its own two-flop synchronizer before any other use.
REQ-009 SHALL run an independent two-state FSM per bit: STABLE and SETTLING.
REQ-010 STABLE: synchronized bit != SW_CLEAN bit -> SETTLING with counter = 0. Otherwise remain in STABLE with counter held at 0.
REQ-011 SETTLING: synchronized bit == SW_CLEAN bit (bounce) -> STABLE, counter = 0, SW_CLEAN unchanged.
REQ-012 SETTLING, bit still differs, counter < DEBOUNCE_CYCLES-1 -> counter increments.
REQ-013 SETTLING, bit still differs, counter == DEBOUNCE_CYCLES-1 -> SW_CLEAN bit takes the synchronized value, state -> STABLE, counter = 0.
REQ-014 Latency: for a clean SW step, SW_CLEAN SHALL update on rising edge DEBOUNCE_CYCLES+3, counting the edge that first samples the new SW value as edge 1.
REQ-015 Counter SHALL be $clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL NOT change SW_CLEAN.
REQ-017 Bits SHALL be fully independent; simultaneous changes on several bits settle in parallel with identical latency.
REQ-018 SW_CLEAN SHALL be driven directly from flops, with no combinational path from SW.

Reset
REQ-019 CPU_RESETN low SHALL immediately clear synchronizer flops, SW_CLEAN to 0, all counters to 0, all FSMs to STABLE, and SW_CHANGED to 0.
REQ-020 Reset asserted mid-SETTLING SHALL abort the settle with no SW_CLEAN update.
REQ-021 After reset release, switches held high SHALL debounce to 1 with normal latency (REQ-014).

Configuration
REQ-022 Macro SW_DEBOUNCE_STROBE_EN defined: SW_CHANGED SHALL be a registered pulse, high for exactly the one cycle in which SW_CLEAN holds a newly updated value. One pulse SHALL be produced when several bits update on the same edge.
REQ-023 Macro SW_DEBOUNCE_STROBE_EN undefined: SW_CHANGED SHALL be tied to constant 0 and no strobe logic SHALL be synthesized. The port list SHALL be unchanged.

Structure
REQ-024 Package sw_debounce_pkg SHALL hold the per-bit state typedef (STABLE, SETTLING) and the default DEBOUNCE_CYCLES constant.
REQ-025 Sub-module debounce_bit SHALL contain one synchronizer, counter and FSM. sw_debounce SHALL instantiate it WIDTH times and add only the strobe OR/register.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-026 Reset with SW=4'b0000, then SW->4'b0001 -> SW_CLEAN=4'b0001 on edge 7 after the change; SW_CHANGED pulses once when the macro is defined.
REQ-027 SW[2] toggles 1,0,1,0 every 2 cycles, then holds at 1 -> no SW_CLEAN change during toggling; SW_CLEAN[2]=1 exactly 7 edges after the final rise.
REQ-028 SW 4'b0000->4'b1111 on one edge -> all four bits update on the same edge; exactly one SW_CHANGED pulse.
REQ-029 SW->4'b1000, CPU_RESETN pulsed low at edge 4 -> SW_CLEAN=0 immediately; after release, SW_CLEAN=4'b1000 seven edges later.
REQ-030 Macro undefined, 4'b0101<->4'b1010 steps held 10 cycles each -> SW_CLEAN follows with latency 7; SW_CHANGED stays 0 throughout.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-bit state encoding and
// the default settle time (10 ms at 100 MHz).
package sw_debounce_pkg;

    // Per-bit debounce state.
    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_t;

    // Default number of consecutive stable cycles before a level is accepted.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Width of the settle counter; it only ever counts 0 .. cycles-1.
    function automatic int db_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchronizer, settle counter and the
// STABLE/SETTLING state machine that owns the clean output level.
// 'update' is high in the cycle before the clean level flips, so the
// parent can register a strobe that lines up with the new value.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic sw_clean,
    output logic update
);

    localparam int CW = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          sync_bit;
    db_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic          clean_reg;
    logic          differs;

    // Two-flop synchronizer: the raw switch is touched nowhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], sw_async};
        end
    end

    assign sync_bit = sync_reg[1];
    assign differs  = (sync_bit != clean_reg);

    // Final settle cycle: the new level has held long enough to be accepted.
    assign update = (state_reg == SETTLING) && differs && (cnt_reg == CNT_LAST);

    // Debounce FSM; the counter is cleared on every exit from SETTLING so it
    // can never run past CNT_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            clean_reg <= 1'b0;
        end else begin
            case (state_reg)
                STABLE: begin
                    cnt_reg <= '0;
                    if (differs) begin
                        state_reg <= SETTLING;
                    end
                end
                SETTLING: begin
                    if (!differs) begin
                        // Bounced back before settling: discard the attempt.
                        state_reg <= STABLE;
                        cnt_reg   <= '0;
                    end else if (update) begin
                        clean_reg <= sync_bit;
                        state_reg <= STABLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= STABLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign sw_clean = clean_reg;

endmodule

// File: rtl/sw_debounce.sv
// Debounced, synchronized board switches feeding the 2-bit adder operands
// (SW[0]=a0, SW[1]=a1, SW[2]=b0, SW[3]=b1 at the default width).
// Optional feature macro: SW_DEBOUNCE_STROBE_EN -- when defined, SW_CHANGED
// is a one-cycle registered pulse aligned with any SW_CLEAN update; when
// undefined, SW_CHANGED is tied low and no strobe logic exists.
// DEBOUNCE_CYCLES must be at least 2.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_CLEAN,
    output logic             SW_CHANGED
);

    logic [WIDTH-1:0] update_bits;

    // One fully independent debounce channel per switch.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk      (CLK100MHZ),
                .rst_n    (CPU_RESETN),
                .sw_async (SW[gi]),
                .sw_clean (SW_CLEAN[gi]),
                .update   (update_bits[gi])
            );
        end
    endgenerate

`ifdef SW_DEBOUNCE_STROBE_EN
    logic changed_reg;

    // Single pulse whenever one or more channels accept a new level together.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |update_bits;
        end
    end

    assign SW_CHANGED = changed_reg;
`else
    logic unused_update;

    assign unused_update = |update_bits;
    assign SW_CHANGED    = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=4, DEBOUNCE_CYCLES=4).
// Stimulus pushes the expected SW_CLEAN value and the cycle it must appear;
// the monitor pops an entry whenever SW_CLEAN changes.
module tb_sw_debounce;

    localparam int WIDTH = 4;
    localparam int DCYC  = 4;
    localparam int LAT   = DCYC + 3;

    logic             CLK100MHZ;
    logic             CPU_RESETN;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] SW_CLEAN;
    logic             SW_CHANGED;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               cyc;
        bit               strobe;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit mon_en  = 0;
    logic [WIDTH-1:0] prev_clean = '0;

    sw_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DCYC)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .SW         (SW),
        .SW_CLEAN   (SW_CLEAN),
        .SW_CHANGED (SW_CHANGED)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per observed SW_CLEAN change.
    always @(negedge CLK100MHZ) begin
        bit   exp_strobe;
        exp_t e;
        exp_strobe = 1'b0;
        if (mon_en) begin
            if (SW_CLEAN !== prev_clean) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", int'(SW_CLEAN), int'(prev_clean));
                end else begin
                    e = sb.pop_front();
                    check("clean_value", int'(SW_CLEAN), int'(e.val));
                    check("clean_cycle", cyc, e.cyc);
                    exp_strobe = e.strobe;
                    $display("txn: SW_CLEAN=%b at cycle %0d SW_CHANGED=%b", SW_CLEAN, cyc, SW_CHANGED);
                end
            end
`ifdef SW_DEBOUNCE_STROBE_EN
            if (SW_CHANGED !== exp_strobe) check("sw_changed", int'(SW_CHANGED), int'(exp_strobe));
            else                           check("sw_changed", 1, 1 - int'(SW_CHANGED === 1'bx));
`else
            if (SW_CHANGED !== 1'b0) check("sw_changed_tied", int'(SW_CHANGED), 0);
            else                     check("sw_changed_tied", 0, int'(SW_CHANGED === 1'bx));
            if (exp_strobe) prev_clean <= SW_CLEAN;
`endif
        end
        prev_clean <= SW_CLEAN;
    end

    task automatic step(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] expv);
        exp_t e;
        @(negedge CLK100MHZ);
        SW       = v;
        e.val    = expv;
        e.cyc    = cyc + LAT;
        e.strobe = 1'b1;
        sb.push_back(e);
    endtask

    task automatic set_sw(input logic [WIDTH-1:0] v);
        @(negedge CLK100MHZ);
        SW = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    initial begin
        exp_t e;
        int   n0;
        CPU_RESETN = 1'b0;
        SW         = '0;
        idle(3);
        check("reset_clean", int'(SW_CLEAN), 0);
        check("reset_changed", int'(SW_CHANGED), 0);
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        mon_en     = 1'b1;

        // Single bit rising step.
        step(4'b0001, 4'b0001);
        idle(12);

        // SW[2] bounces with 2-cycle pulses, then holds high.
        set_sw(4'b0101); idle(1);
        set_sw(4'b0001); idle(1);
        set_sw(4'b0101); idle(1);
        set_sw(4'b0001); idle(1);
        step(4'b0101, 4'b0101);
        idle(12);

        // All bits together: back to zero, then all high in one step.
        step(4'b0000, 4'b0000);
        idle(12);
        step(4'b1111, 4'b1111);
        idle(12);

        // Reset in the middle of a settle.
        @(negedge CLK100MHZ);
        SW = 4'b1000;
        n0 = cyc;
        repeat (4) @(posedge CLK100MHZ);
        #1;
        e.val    = 4'b0000;
        e.cyc    = n0 + 4;
        e.strobe = 1'b0;
        sb.push_back(e);
        CPU_RESETN = 1'b0;
        #1;
        check("reset_immediate_clean", int'(SW_CLEAN), 0);
        check("reset_immediate_changed", int'(SW_CHANGED), 0);
        idle(2);
        CPU_RESETN = 1'b1;
        e.val    = 4'b1000;
        e.cyc    = cyc + LAT;
        e.strobe = 1'b1;
        sb.push_back(e);
        idle(12);

        // Alternating patterns held 10 cycles each.
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] v;
            v = (i % 2 == 0) ? 4'b0101 : 4'b1010;
            step(v, v);
            idle(9);
        end
        idle(12);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
